// File: rtl/dsp_alu_pkg.sv
// dsp_alu_pkg: shared types and elaboration limits for the dsp_alu_simd primitive.
//   op_t          : beat operation (ADD, SUB, ACC, CLR)
//   MAX_DSP_WIDTH : total packed operand width a single DSP slice can hold
//   MAX_LANES     : upper bound on SIMD lanes
//   MAX_LATENCY   : upper bound on pipeline depth
package dsp_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    localparam int MAX_DSP_WIDTH = 48;
    localparam int MAX_LANES     = 8;
    localparam int MAX_LATENCY   = 4;

endpackage

// File: rtl/dsp_alu_simd_if.sv
// dsp_alu_simd_if: beat interface for dsp_alu_simd.
//   in_valid, op, a, b : input beat (driven by master)
//   out_valid, y       : result beat (driven by slave), no backpressure
interface dsp_alu_simd_if
    import dsp_alu_pkg::*;
#(
    parameter int width = 8,
    parameter int lanes = 4
);
    logic                     in_valid;
    op_t                      op;
    logic [lanes*width-1:0]   a;
    logic [lanes*width-1:0]   b;
    logic                     out_valid;
    logic [lanes*width-1:0]   y;

    modport master (
        output in_valid, op, a, b,
        input  out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b,
        output out_valid, y
    );
endinterface

// File: rtl/dsp_alu_lane.sv
// dsp_alu_lane: one SIMD lane of stage 1 -- computes the result and owns the
// lane accumulator. Both the result and accumulator only change on en.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   en           : beat accepted this cycle
//   op, a, b     : operation and lane operands
//   res          : registered stage-1 lane result
// Build option: DSP_ALU_SIMD_SAT_EN selects signed saturating ADD/SUB/ACC.
module dsp_alu_lane
    import dsp_alu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  op_t               op,
    input  logic [width-1:0]  a,
    input  logic [width-1:0]  b,
    output logic [width-1:0]  res
);

    logic [width-1:0] acc;
    logic [width-1:0] nxt_acc;
    logic [width-1:0] nxt_res;

    function automatic logic [width-1:0] arith(input logic [width-1:0] x,
                                               input logic [width-1:0] z,
                                               input logic             sub);
`ifdef DSP_ALU_SIMD_SAT_EN
        logic [width:0] s;
        // One guard bit of sign extension; a disagreement between the two
        // top bits means the signed result left the representable range.
        s = sub ? ({x[width-1], x} - {z[width-1], z})
                : ({x[width-1], x} + {z[width-1], z});
        if (s[width] != s[width-1])
            return s[width] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
        return s[width-1:0];
`else
        return sub ? (x - z) : (x + z);
`endif
    endfunction

    always_comb begin
        nxt_acc = acc;
        nxt_res = res;
        unique case (op)
            OP_ADD: nxt_res = arith(a, b, 1'b0);
            OP_SUB: nxt_res = arith(a, b, 1'b1);
            OP_ACC: begin
                nxt_acc = arith(acc, a, 1'b0);
                nxt_res = nxt_acc;
            end
            OP_CLR: begin
                nxt_acc = '0;
                nxt_res = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            res <= '0;
        end else if (en) begin
            acc <= nxt_acc;
            res <= nxt_res;
        end
    end

endmodule

// File: rtl/dsp_alu_simd.sv
// dsp_alu_simd: multi-lane SIMD add/sub/accumulate/clear DSP primitive.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : in_valid/op/a/b beat in, out_valid/y result out
// Stage 1 lives in the lane instances; stages 2..latency are pure delay
// registers here. Data registers load only on valid so y holds its last
// result across bubbles.
// Build option: DSP_ALU_SIMD_SAT_EN enables per-lane signed saturation.
module dsp_alu_simd
    import dsp_alu_pkg::*;
#(
    parameter int width   = 8,
    parameter int lanes   = 4,
    parameter int latency = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    dsp_alu_simd_if.slave        bus
);

    localparam int W = lanes * width;

    if (width < 2 || width > MAX_DSP_WIDTH) begin : g_bad_width
        $error("dsp_alu_simd: width out of range");
    end
    if (lanes < 1 || lanes > MAX_LANES) begin : g_bad_lanes
        $error("dsp_alu_simd: lanes out of range");
    end
    if (W > MAX_DSP_WIDTH) begin : g_bad_total
        $error("dsp_alu_simd: lanes*width exceeds DSP width");
    end
    if (latency < 1 || latency > MAX_LATENCY) begin : g_bad_latency
        $error("dsp_alu_simd: latency out of range");
    end

    logic [W-1:0]       lane_y;
    logic [W-1:0]       y_out;
    logic [latency-1:0] vld;

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        dsp_alu_lane #(.width(width)) u_lane (
            .clock (clock),
            .reset (reset),
            .en    (bus.in_valid),
            .op    (bus.op),
            .a     (bus.a[i*width +: width]),
            .b     (bus.b[i*width +: width]),
            .res   (lane_y[i*width +: width])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
        end else begin
            vld[0] <= bus.in_valid;
            for (int i = 1; i < latency; i++)
                vld[i] <= vld[i-1];
        end
    end

    if (latency == 1) begin : g_no_delay
        assign y_out = lane_y;
    end else begin : g_delay
        logic [W-1:0] dly_d [latency-1];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < latency-1; i++)
                    dly_d[i] <= '0;
            end else begin
                if (vld[0])
                    dly_d[0] <= lane_y;
                for (int i = 1; i < latency-1; i++)
                    if (vld[i])
                        dly_d[i] <= dly_d[i-1];
            end
        end

        assign y_out = dly_d[latency-2];
    end

    assign bus.y         = y_out;
    assign bus.out_valid = vld[latency-1];

endmodule
